// File: rtl/led_ctl_pkg.sv
// Shared types and page numbering for the front-panel LED display path.
// The page constants are also used by the LED mux so both sides agree on page meaning.
package led_ctl_pkg;

  typedef enum logic [1:0] {
    StManual,
    StAuto,
    StAlert
  } led_state_e;

  localparam int unsigned PAGE_STATUS    = 0;
  localparam int unsigned PAGE_PC        = 1;
  localparam int unsigned PAGE_BDADDR_LO = 2;
  localparam int unsigned PAGE_BDADDR_HI = 3;
  localparam int unsigned PAGE_BDST      = 4;
  localparam int unsigned PAGE_LC_LO     = 5;
  localparam int unsigned PAGE_LC_HI     = 6;
  localparam int unsigned PAGE_PC_BOOT   = 7;

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after the pointer.
// The pointer is owned and advanced by the parent.
module led_rr_arbiter
  import led_ctl_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IW'((32'(pointer) + i) % NREQ);
      if (enable && !found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/led_page_scheduler.sv
// Chooses the LED page (manual, auto-rotate or timed alert) and produces the PWM LED gate.
// Alerts from several requesters are admitted one at a time through a round-robin arbiter.
module led_page_scheduler
  import led_ctl_pkg::*;
#(
  parameter int unsigned NPAGES       = 8,
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned FLASH_CYCLES = 100_000_000,
  parameter int unsigned PWM_BITS     = 8,
  localparam int unsigned PW = $clog2(NPAGES)
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 mode_auto,
  input  logic [PW-1:0]        manual_page,
  input  logic [NPAGES-1:0]    page_mask,
  input  logic [PWM_BITS-1:0]  brightness,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*PW-1:0]   req_page,
  output logic [NREQ-1:0]      gnt,
  output logic [PW-1:0]        page_sel,
  output logic                 led_enable,
  output logic                 alert_active
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DW = $clog2(DWELL_CYCLES);
  localparam int unsigned FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  led_state_e          state_q, state_d;
  logic [PW-1:0]       page_q, page_d;
  logic [PW-1:0]       saved_q, saved_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [FW-1:0]       flash_q, flash_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic                led_q, led_d;
  logic                alert_q, alert_d;

  logic [NREQ-1:0]     arb_grant;
  logic [IW-1:0]       arb_idx;
  logic [PW-1:0]       req_pages [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_req_pages
    assign req_pages[g] = req_page[g*PW +: PW];
  end

  // Next index above cur (wrapping) whose mask bit is set; cur itself only if it is the sole one.
  function automatic logic [PW-1:0] next_page(input logic [PW-1:0]     cur,
                                              input logic [NPAGES-1:0] mask);
    logic [PW-1:0] res;
    logic [PW-1:0] idx;
    logic          found;
    res   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NPAGES; i++) begin
      idx = PW'((32'(cur) + i) % NPAGES);
      if (!found && mask[idx]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return res;
  endfunction

  led_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req),
    .pointer   (ptr_q),
    .enable    (state_q != StAlert),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    saved_d = saved_q;
    dwell_d = dwell_q;
    flash_d = flash_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    pwm_d   = pwm_q + 1'b1;

    unique case (state_q)
      StManual, StAuto: begin
        if (|arb_grant) begin
          // Alert entry outranks both the mode change and the dwell advance.
          gnt_d   = arb_grant;
          saved_d = page_q;
          page_d  = req_pages[arb_idx];
          state_d = StAlert;
          flash_d = '0;
          ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end else if (state_q == StManual) begin
          if (mode_auto) begin
            state_d = StAuto;
            dwell_d = '0;
          end else begin
            page_d = manual_page;
          end
        end else if (!mode_auto) begin
          state_d = StManual;
        end else if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
          dwell_d = '0;
          page_d  = next_page(page_q, page_mask);
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StAlert: begin
        if (flash_q == FW'(FLASH_CYCLES - 1)) begin
          state_d = mode_auto ? StAuto : StManual;
          page_d  = saved_q;
          dwell_d = '0;
        end else begin
          flash_d = flash_q + 1'b1;
        end
      end
      default: state_d = StManual;
    endcase

    alert_d = (state_d == StAlert);
    led_d   = (state_d == StAlert) || (pwm_q < brightness);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= StManual;
      page_q  <= '0;
      saved_q <= '0;
      dwell_q <= '0;
      flash_q <= '0;
      pwm_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      led_q   <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      saved_q <= saved_d;
      dwell_q <= dwell_d;
      flash_q <= flash_d;
      pwm_q   <= pwm_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      alert_q <= alert_d;
    end
  end

  assign gnt          = gnt_q;
  assign page_sel     = page_q;
  assign led_enable   = led_q;
  assign alert_active = alert_q;

endmodule

// File: tb/tb_led_page_scheduler.sv
// Cycle-by-cycle vector table for the LED page scheduler plus PWM duty-count sequences.
module tb_led_page_scheduler;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        mode_auto;
  logic [2:0]  manual_page;
  logic [7:0]  page_mask;
  logic [3:0]  brightness;
  logic [3:0]  req;
  logic [11:0] req_page;
  logic [3:0]  gnt;
  logic [2:0]  page_sel;
  logic        led_enable;
  logic        alert_active;

  always #5 sysclk = ~sysclk;

  led_page_scheduler #(
    .NPAGES       (8),
    .NREQ         (4),
    .DWELL_CYCLES (4),
    .FLASH_CYCLES (3),
    .PWM_BITS     (4)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .mode_auto    (mode_auto),
    .manual_page  (manual_page),
    .page_mask    (page_mask),
    .brightness   (brightness),
    .req          (req),
    .req_page     (req_page),
    .gnt          (gnt),
    .page_sel     (page_sel),
    .led_enable   (led_enable),
    .alert_active (alert_active)
  );

  // One record per clock: inputs during the cycle, outputs expected just after its edge.
  // Brightness is 0 in the table, so the LED gate must equal alert_active.
  typedef struct {
    logic       rst;
    logic       mode;
    logic [2:0] mpage;
    logic [7:0] mask;
    logic [3:0] rq;
    logic [2:0] page;
    logic [3:0] g;
    logic       alert;
  } vec_t;

  typedef struct {
    logic [2:0] page;
    logic [3:0] g;
    logic       alert;
    logic       led;
  } exp_t;

  vec_t        vecs[$];
  exp_t        exp_q[$];
  int unsigned exp_cnt_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic add(input int n, input logic rst, input logic mode, input logic [2:0] mpage,
                     input logic [7:0] mask, input logic [3:0] rq, input logic [2:0] page,
                     input logic [3:0] g, input logic alert);
    vec_t v;
    v = '{rst: rst, mode: mode, mpage: mpage, mask: mask, rq: rq, page: page, g: g,
          alert: alert};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int unsigned act,
                       input int unsigned req_v);
    if (act !== req_v) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, act, req_v);
    end
  endtask

  task automatic pwm_count(input logic [3:0] b);
    int unsigned cnt;
    @(negedge sysclk);
    brightness = b;
    exp_cnt_q.push_back(int'(b));
    repeat (2) @(posedge sysclk);
    cnt = 0;
    repeat (16) begin
      @(posedge sysclk);
      #1;
      cnt += int'(led_enable);
    end
    n_vec++;
    check("pwm_high_count", int'(b), cnt, exp_cnt_q.pop_front());
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [7:0] A5 = 8'b1010_0101;
    localparam logic [3:0] B  = 4'b1011;
    exp_t e;

    reset       = 1'b1;
    mode_auto   = 1'b0;
    manual_page = 3'd0;
    page_mask   = A5;
    brightness  = 4'd0;
    req         = 4'd0;
    req_page    = {3'd4, 3'd2, 3'd6, 3'd3};

    // Manual tracking
    add(1, 1, 0, 5, A5, 0, 0, 0, 0);
    add(1, 0, 0, 5, A5, 0, 5, 0, 0);
    add(1, 0, 0, 2, A5, 0, 2, 0, 0);
    add(1, 0, 0, 0, A5, 0, 0, 0, 0);
    // Auto rotation 0,2,5,7,0,2 with 4-cycle dwell
    add(4, 0, 1, 0, A5, 0, 0, 0, 0);
    add(4, 0, 1, 0, A5, 0, 2, 0, 0);
    add(4, 0, 1, 0, A5, 0, 5, 0, 0);
    add(4, 0, 1, 0, A5, 0, 7, 0, 0);
    add(4, 0, 1, 0, A5, 0, 0, 0, 0);
    add(1, 0, 1, 0, A5, 0, 2, 0, 0);
    // Alert on page 2 in auto, then a fresh dwell on page 2
    add(1, 0, 1, 0, A5, 4'b0010, 6, 4'b0010, 1);
    add(2, 0, 1, 0, A5, 0, 6, 0, 1);
    add(4, 0, 1, 0, A5, 0, 2, 0, 0);
    add(1, 0, 1, 0, A5, 0, 5, 0, 0);
    // Empty mask, then a mask holding only the current page
    add(3, 0, 1, 0, 8'h00, 0, 5, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 0, 0, 0);
    add(4, 0, 1, 0, 8'h01, 0, 0, 0, 0);
    // Round robin with req held
    add(1, 1, 0, 0, A5, 0, 0, 0, 0);
    add(1, 0, 0, 0, A5, B, 3, 4'b0001, 1);
    add(2, 0, 0, 0, A5, B, 3, 0, 1);
    add(1, 0, 0, 0, A5, B, 0, 0, 0);
    add(1, 0, 0, 0, A5, B, 6, 4'b0010, 1);
    add(2, 0, 0, 0, A5, B, 6, 0, 1);
    add(1, 0, 0, 0, A5, B, 0, 0, 0);
    add(1, 0, 0, 0, A5, B, 4, 4'b1000, 1);
    add(2, 0, 0, 0, A5, B, 4, 0, 1);
    add(1, 0, 0, 0, A5, B, 0, 0, 0);
    add(1, 0, 0, 0, A5, B, 3, 4'b0001, 1);
    add(1, 0, 0, 0, A5, B, 3, 0, 1);
    // Reset during the alert; bit 0 wins again after release
    add(2, 1, 0, 0, A5, B, 0, 0, 0);
    add(1, 0, 0, 0, A5, B, 3, 4'b0001, 1);
    add(2, 0, 0, 0, A5, B, 3, 0, 1);
    add(1, 0, 0, 0, A5, 0, 0, 0, 0);
    // Alert beats a same-cycle mode change; manual return shows saved page for one cycle
    add(1, 0, 0, 1, A5, 0, 1, 0, 0);
    add(1, 0, 1, 7, A5, 4'b0100, 2, 4'b0100, 1);
    add(2, 0, 0, 7, A5, 0, 2, 0, 1);
    add(1, 0, 0, 7, A5, 0, 1, 0, 0);
    add(1, 0, 0, 7, A5, 0, 7, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge sysclk);
      reset       = vecs[i].rst;
      mode_auto   = vecs[i].mode;
      manual_page = vecs[i].mpage;
      page_mask   = vecs[i].mask;
      req         = vecs[i].rq;
      exp_q.push_back('{page: vecs[i].page, g: vecs[i].g, alert: vecs[i].alert,
                        led: vecs[i].alert});
      @(posedge sysclk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      check("page_sel", i, int'(page_sel), int'(e.page));
      check("gnt", i, int'(gnt), int'(e.g));
      check("alert_active", i, int'(alert_active), int'(e.alert));
      check("led_enable", i, int'(led_enable), int'(e.led));
    end

    pwm_count(4'd4);
    pwm_count(4'd15);
    pwm_count(4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
